// File: rtl/flt_add_engine.sv
// Memory-mapped 16-bit floating-point adder.
// Loads two operands byte by byte, adds them in a fixed sequence of one-cycle
// steps (align, add, normalize, round) and writes the result back as two bytes.
module flt_add_engine (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic       mem_wr_en,
    output logic [7:0] mem_wdata
);

    localparam logic [7:0] AddrAMsb = 8'd128;
    localparam logic [7:0] AddrALsb = 8'd129;
    localparam logic [7:0] AddrBMsb = 8'd130;
    localparam logic [7:0] AddrBLsb = 8'd131;
    localparam logic [7:0] AddrRMsb = 8'd132;
    localparam logic [7:0] AddrRLsb = 8'd133;

    typedef enum logic [3:0] {
        StIdle, StLd0, StLd1, StLd2, StLd3, StAlign, StAdd,
        StNorm, StRound, StSt0, StSt1, StDone
    } state_e;

    state_e state_q, state_d;

    // Operands as loaded from memory
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    // Pipeline of the arithmetic steps; mantissas carry 3 extra bits (guard, round, sticky)
    logic              sign_q, sign_d;
    logic signed [6:0] exp_q, exp_d;
    logic [13:0]       big_q, big_d;
    logic [13:0]       sml_q, sml_d;
    logic              sub_q, sub_d;
    logic              bypass_q, bypass_d;
    logic [14:0]       sum_q, sum_d;
    logic [13:0]       norm_q, norm_d;
    logic              zero_q, zero_d;
    logic [15:0]       result_q, result_d;

    // Alignment helpers
    logic        a_zero, b_zero, a_larger;
    logic [15:0] big_op;
    logic [14:0] sml_mag;
    logic [4:0]  exp_diff;
    logic [13:0] sml_ext, sml_shift, sml_lost, sml_algn;
    logic [15:0] byp_val;
    // Normalization helpers
    logic [3:0]        lz_cnt;
    logic              lz_found;
    logic [13:0]       norm_m;
    logic signed [6:0] norm_e;
    // Rounding helpers
    logic              round_up;
    logic [11:0]       mant_rnd;
    logic [9:0]        frac_fin;
    logic signed [6:0] exp_fin;
    logic [15:0]       rnd_res;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fixed sequence, start high aborts any busy state back to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  state_d = start ? StIdle : StLd0;
            StLd0:   state_d = start ? StIdle : StLd1;
            StLd1:   state_d = start ? StIdle : StLd2;
            StLd2:   state_d = start ? StIdle : StLd3;
            StLd3:   state_d = start ? StIdle : StAlign;
            StAlign: state_d = start ? StIdle : StAdd;
            StAdd:   state_d = start ? StIdle : StNorm;
            StNorm:  state_d = start ? StIdle : StRound;
            StRound: state_d = start ? StIdle : StSt0;
            StSt0:   state_d = start ? StIdle : StSt1;
            StSt1:   state_d = start ? StIdle : StDone;
            StDone:  state_d = start ? StIdle : StDone;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state only
    always_comb begin
        done      = 1'b0;
        mem_addr  = AddrAMsb;
        mem_wr_en = 1'b0;
        mem_wdata = 8'd0;
        case (state_q)
            StLd0: mem_addr = AddrAMsb;
            StLd1: mem_addr = AddrALsb;
            StLd2: mem_addr = AddrBMsb;
            StLd3: mem_addr = AddrBLsb;
            StSt0: begin
                mem_addr  = AddrRMsb;
                mem_wr_en = 1'b1;
                mem_wdata = result_q[15:8];
            end
            StSt1: begin
                mem_addr  = AddrRLsb;
                mem_wr_en = 1'b1;
                mem_wdata = result_q[7:0];
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Pick the larger magnitude and shift the smaller mantissa into line with it
    always_comb begin
        a_zero   = (op_a_q[14:10] == 5'd0);
        b_zero   = (op_b_q[14:10] == 5'd0);
        a_larger = (op_a_q[14:0] >= op_b_q[14:0]);
        big_op   = a_larger ? op_a_q : op_b_q;
        sml_mag  = a_larger ? op_b_q[14:0] : op_a_q[14:0];
        exp_diff = big_op[14:10] - sml_mag[14:10];
        sml_ext  = {1'b1, sml_mag[9:0], 3'b000};
        {sml_shift, sml_lost} = {sml_ext, 14'd0} >> exp_diff;
        if (exp_diff > 5'd13) begin
            // Entire mantissa lies below the sticky position
            sml_algn = 14'd1;
        end else begin
            sml_algn = {sml_shift[13:1], sml_shift[0] | (|sml_lost)};
        end
        if (a_zero && b_zero) begin
            byp_val = 16'h0000;
        end else if (a_zero) begin
            byp_val = op_b_q;
        end else begin
            byp_val = op_a_q;
        end
    end

    // Leading-zero count of the raw sum (bit 13 is the hidden-bit position)
    always_comb begin
        lz_cnt   = 4'd0;
        lz_found = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            if (!lz_found && sum_q[i]) begin
                lz_cnt   = 4'(13 - i);
                lz_found = 1'b1;
            end
        end
    end

    // Single-step normalization; the right shift folds the dropped bit into sticky
    always_comb begin
        if (sum_q[14]) begin
            norm_m = {sum_q[14:2], sum_q[1] | sum_q[0]};
            norm_e = exp_q + 7'sd1;
        end else begin
            norm_m = sum_q[13:0] << lz_cnt;
            norm_e = exp_q - $signed({3'b000, lz_cnt});
        end
    end

    // Round to nearest even, then apply flush-to-zero and saturation
    always_comb begin
        round_up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
        mant_rnd = {1'b0, norm_q[13:3]} + {11'd0, round_up};
        if (mant_rnd[11]) begin
            frac_fin = mant_rnd[10:1];
            exp_fin  = exp_q + 7'sd1;
        end else begin
            frac_fin = mant_rnd[9:0];
            exp_fin  = exp_q;
        end
        if (zero_q) begin
            rnd_res = 16'h0000;
        end else if (exp_fin < 7'sd1) begin
            rnd_res = {sign_q, 15'd0};
        end else if (exp_fin > 7'sd31) begin
            rnd_res = {sign_q, 15'h7fff};
        end else begin
            rnd_res = {sign_q, exp_fin[4:0], frac_fin};
        end
    end

    // Datapath next-state, one arithmetic step per state
    always_comb begin
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        big_d    = big_q;
        sml_d    = sml_q;
        sub_d    = sub_q;
        bypass_d = bypass_q;
        sum_d    = sum_q;
        norm_d   = norm_q;
        zero_d   = zero_q;
        result_d = result_q;
        case (state_q)
            StLd0: op_a_d[15:8] = mem_rdata;
            StLd1: op_a_d[7:0]  = mem_rdata;
            StLd2: op_b_d[15:8] = mem_rdata;
            StLd3: op_b_d[7:0]  = mem_rdata;
            StAlign: begin
                sign_d   = big_op[15];
                exp_d    = {2'b00, big_op[14:10]};
                big_d    = {1'b1, big_op[9:0], 3'b000};
                sml_d    = sml_algn;
                sub_d    = op_a_q[15] ^ op_b_q[15];
                bypass_d = a_zero | b_zero;
                // A zero operand passes the other one through untouched
                if (a_zero || b_zero) begin
                    result_d = byp_val;
                end
            end
            StAdd: begin
                if (sub_q) begin
                    sum_d = {1'b0, big_q} - {1'b0, sml_q};
                end else begin
                    sum_d = {1'b0, big_q} + {1'b0, sml_q};
                end
            end
            StNorm: begin
                norm_d = norm_m;
                exp_d  = norm_e;
                zero_d = (sum_q == 15'd0);
            end
            StRound: begin
                if (!bypass_q) begin
                    result_d = rnd_res;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a_q   <= 16'd0;
            op_b_q   <= 16'd0;
            sign_q   <= 1'b0;
            exp_q    <= 7'sd0;
            big_q    <= 14'd0;
            sml_q    <= 14'd0;
            sub_q    <= 1'b0;
            bypass_q <= 1'b0;
            sum_q    <= 15'd0;
            norm_q   <= 14'd0;
            zero_q   <= 1'b0;
            result_q <= 16'd0;
        end else begin
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            big_q    <= big_d;
            sml_q    <= sml_d;
            sub_q    <= sub_d;
            bypass_q <= bypass_d;
            sum_q    <= sum_d;
            norm_q   <= norm_d;
            zero_q   <= zero_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_flt_add_engine.sv
// Directed and random bench for flt_add_engine with a byte-wide memory model
// and an exact-arithmetic reference for the adder.
module tb_flt_add_engine;

    logic       clk;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;

    logic [7:0] mem [256];
    int         wr_count;
    int         n_checks;
    int         n_pass;

    // DONE is the twelfth state of the sequence; it is entered on the 11th edge,
    // counting the edge that leaves IDLE as the first.
    localparam int LatencyEdges = 11;

    flt_add_engine dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] = mem_wdata;
            wr_count = wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Exact sum on scaled integers, then round to nearest even
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        longint sa, sb, s, m, mant, rem, half;
        int     p, e, ea, eb;
        logic   sg;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        if (ea == 0 && eb == 0) return 16'h0000;
        if (ea == 0) return b;
        if (eb == 0) return a;
        sa = longint'({1'b1, a[9:0]}) << (ea - 1);
        sb = longint'({1'b1, b[9:0]}) << (eb - 1);
        if (a[15]) sa = -sa;
        if (b[15]) sb = -sb;
        s = sa + sb;
        if (s == 0) return 16'h0000;
        sg = (s < 0);
        m  = sg ? -s : s;
        p  = 0;
        for (int i = 0; i < 63; i++) begin
            if (m[i]) p = i;
        end
        e = p - 9;
        if (p >= 10) begin
            mant = m >> (p - 10);
            rem  = m - (mant << (p - 10));
            half = (p > 10) ? (longint'(1) << (p - 11)) : 0;
            if (p > 10 && (rem > half || (rem == half && mant[0]))) mant++;
            if (mant == 2048) begin
                mant = 1024;
                e++;
            end
        end else begin
            mant = m << (10 - p);
        end
        if (e < 1) return {sg, 15'd0};
        if (e > 31) return {sg, 15'h7fff};
        return {sg, e[4:0], mant[9:0]};
    endfunction

    // One full operation from IDLE (start high, negedge phase) back to IDLE
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input string tag);
        int edges;
        mem[128] = a[15:8];
        mem[129] = a[7:0];
        mem[130] = b[15:8];
        mem[131] = b[7:0];
        mem[132] = 8'hee;
        mem[133] = 8'hee;
        start = 1'b0;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!done && edges < 40);
        check({tag, " latency"}, edges, LatencyEdges);
        check({tag, " result"}, {mem[132], mem[133]}, exp_res);
        repeat (3) @(negedge clk);
        check({tag, " done held"}, done, 1);
        start = 1'b1;
        @(negedge clk);
        check({tag, " done clear"}, done, 0);
    endtask

    logic [15:0] vec_a [12] = '{16'h1a04, 16'h4204, 16'h4204, 16'h3c00, 16'h3c01, 16'h7fff,
                                16'h0000, 16'h3c00, 16'h8401, 16'h0123, 16'h8000, 16'h3c00};
    logic [15:0] vec_b [12] = '{16'h1a04, 16'hc204, 16'h4204, 16'h1000, 16'h1000, 16'h7fff,
                                16'hbc00, 16'hb800, 16'h0400, 16'h3c00, 16'h0001, 16'h8400};
    logic [15:0] vec_r [12] = '{16'h1e04, 16'h0000, 16'h4604, 16'h3c00, 16'h3c02, 16'h7fff,
                                16'hbc00, 16'h3800, 16'h8000, 16'h3c00, 16'h0000, 16'h3c00};

    initial begin
        logic [15:0] ra, rb;
        int          wr_before;
        n_checks = 0;
        n_pass   = 0;
        wr_count = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst done", done, 0);
        check("rst wr_en", mem_wr_en, 0);
        check("rst addr", mem_addr, 128);
        check("rst wdata", mem_wdata, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle addr", mem_addr, 128);
        check("idle done", done, 0);

        for (int i = 0; i < 12; i++) begin
            run_op(vec_a[i], vec_b[i], vec_r[i], $sformatf("vec%0d", i));
        end

        // Abort from ALIGN: nothing written, done never rises
        mem[128] = 8'h42; mem[129] = 8'h04; mem[130] = 8'h42; mem[131] = 8'h04;
        mem[132] = 8'h5a; mem[133] = 8'h5a;
        wr_before = wr_count;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("abort addr", mem_addr, 128);
        check("abort done", done, 0);
        repeat (15) @(negedge clk);
        check("abort done later", done, 0);
        check("abort writes", wr_count - wr_before, 0);
        check("abort mem132", mem[132], 8'h5a);
        check("abort mem133", mem[133], 8'h5a);

        // Reset during ST0: MSB write commits, LSB write is suppressed
        mem[132] = 8'h5a; mem[133] = 8'h5a;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("st0 wr_en", mem_wr_en, 1);
        check("st0 addr", mem_addr, 132);
        reset = 1'b1;
        @(negedge clk);
        check("rst mid wr_en", mem_wr_en, 0);
        check("rst mid addr", mem_addr, 128);
        check("rst mid wdata", mem_wdata, 0);
        check("rst mid done", done, 0);
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst mid mem133", mem[133], 8'h5a);
        check("rst mid mem132", mem[132], 8'h46);
        check("rst mid idle done", done, 0);

        // Back-to-back random pairs against the exact reference
        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 3 != 0) rb[14:10] = ra[14:10] + 5'($urandom_range(0, 2));
            run_op(ra, rb, ref_add(ra, rb), $sformatf("rnd%0d a=%h b=%h", i, ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
